fifo_enq_arbiter: RTL and testbench



---
 rtl/fifo_enq_arbiter.sv | 137 +++++++++++++
 tb/tb_fifo_enq_arbiter.sv | 165 ++++++++++++++++
 2 files changed

// File: rtl/fifo_enq_arbiter.sv
// Round-robin arbiter that shares the enqueue side of one fifo between four
// val/rdy producers. A grant lasts up to MAX_BURST beats, then ownership rotates.
// When a grant is released, the next owner is chosen in the same cycle, so
// back-to-back grants have no bubble.
//
// Ports:
//   clk       clock, all state updates on the rising edge
//   reset     synchronous, active-high reset
//   req_val   per-requester valid
//   req_data  flattened data, requester i at [i*DATA_W +: DATA_W]
//   req_rdy   per-requester ready, one-hot or zero
//   enq_val   valid to fifo enqueue
//   enq_data  data to fifo enqueue
//   enq_id    index of the current owner
//   enq_rdy   ready from fifo enqueue
//   busy      high while a requester holds the grant
module fifo_enq_arbiter #(
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned NREQ      = 4,  // only 4 is supported (2-bit ids)
    parameter int unsigned MAX_BURST = 4   // 1..15
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic [NREQ-1:0]        req_val,
    input  logic [NREQ*DATA_W-1:0] req_data,
    output logic [NREQ-1:0]        req_rdy,
    output logic                   enq_val,
    output logic [DATA_W-1:0]      enq_data,
    output logic [1:0]             enq_id,
    input  logic                   enq_rdy,
    output logic                   busy
);

    typedef enum logic {StIdle, StBusy} state_e;

    localparam logic [3:0] LastBeat = 4'(MAX_BURST - 1);

    state_e     state_q, state_d;
    logic [1:0] owner_q, owner_d;
    logic [1:0] ptr_q, ptr_d;
    logic [3:0] beat_q, beat_d;

    // Rotating priority scan: returns {found, index}, first set bit at or after start.
    function automatic logic [2:0] pick(input logic [3:0] val, input logic [1:0] start);
        logic       found;
        logic [1:0] idx;
        logic [1:0] win;
        found = 1'b0;
        win   = 2'd0;
        for (int i = 0; i < 4; i++) begin
            idx = start + 2'(i);
            if (!found && val[idx]) begin
                found = 1'b1;
                win   = idx;
            end
        end
        return {found, win};
    endfunction

    logic [DATA_W-1:0] owner_data;
    logic              owner_val;
    logic              xfer;
    logic              release_grant;
    logic [2:0]        idle_pick;
    logic [2:0]        rot_pick;

    assign owner_data    = req_data[int'(owner_q) * DATA_W +: DATA_W];
    assign owner_val     = req_val[owner_q];
    assign xfer          = owner_val && enq_rdy;
    assign release_grant = (xfer && (beat_q == LastBeat)) || !owner_val;
    assign idle_pick     = pick(req_val, ptr_q);
    // Releasing owner is scanned last, so it only wins again when it is alone.
    assign rot_pick      = pick(req_val, owner_q + 2'd1);

    always_comb begin
        state_d = state_q;
        owner_d = owner_q;
        ptr_d   = ptr_q;
        beat_d  = beat_q;
        unique case (state_q)
            StIdle: begin
                if (idle_pick[2]) begin
                    owner_d = idle_pick[1:0];
                    beat_d  = 4'd0;
                    state_d = StBusy;
                end
            end
            StBusy: begin
                if (release_grant) begin
                    ptr_d = owner_q + 2'd1;
                    if (rot_pick[2]) begin
                        owner_d = rot_pick[1:0];
                        beat_d  = 4'd0;
                    end else begin
                        state_d = StIdle;
                    end
                end else if (xfer) begin
                    beat_d = beat_q + 4'd1;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // Outputs are forced quiet while reset is high so an abandoned burst
    // cannot hand a beat to the fifo in the reset cycle.
    always_comb begin
        enq_val  = 1'b0;
        enq_data = '0;
        enq_id   = owner_q;
        req_rdy  = '0;
        busy     = 1'b0;
        if (reset) begin
            enq_id = 2'd0;
        end else if (state_q == StBusy) begin
            enq_val          = owner_val;
            enq_data         = owner_data;
            req_rdy[owner_q] = enq_rdy;
            busy             = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= StIdle;
            owner_q <= 2'd0;
            ptr_q   <= 2'd0;
            beat_q  <= 4'd0;
        end else begin
            state_q <= state_d;
            owner_q <= owner_d;
            ptr_q   <= ptr_d;
            beat_q  <= beat_d;
        end
    end

endmodule

// File: tb/tb_fifo_enq_arbiter.sv
// Table-driven bench for fifo_enq_arbiter. Each record gives one cycle of
// inputs and the outputs expected during that cycle. Producers send
// data_of(i, k) where k counts their completed handshakes; the table states
// which beat k each output cycle should carry.
module tb_fifo_enq_arbiter;

    localparam int DW = 32;

    logic            clk = 1'b0;
    logic            reset;
    logic [3:0]      req_val;
    logic [4*DW-1:0] req_data;
    logic [3:0]      req_rdy;
    logic            enq_val;
    logic [DW-1:0]   enq_data;
    logic [1:0]      enq_id;
    logic            enq_rdy;
    logic            busy;

    fifo_enq_arbiter #(.DATA_W(DW), .NREQ(4), .MAX_BURST(4)) dut (
        .clk      (clk),
        .reset    (reset),
        .req_val  (req_val),
        .req_data (req_data),
        .req_rdy  (req_rdy),
        .enq_val  (enq_val),
        .enq_data (enq_data),
        .enq_id   (enq_id),
        .enq_rdy  (enq_rdy),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic       rst;
        logic [3:0] val;
        logic       rdy;
        logic       e_val;
        logic [1:0] e_id;
        logic [3:0] e_rrdy;
        logic       e_busy;
        int         e_k;
    } vec_t;

    vec_t vecs[$];
    int   n_tests = 0;
    int   n_fail  = 0;
    int   k[4];

    function automatic logic [DW-1:0] data_of(input int i, input int kk);
        return DW'(i * 256 + 25 + 10 * kk);
    endfunction

    task automatic v(input int rst, input int val, input int rdy, input int ev, input int eid,
                     input int errdy, input int ebusy, input int ek);
        vec_t t;
        t.rst    = 1'(rst);
        t.val    = 4'(val);
        t.rdy    = 1'(rdy);
        t.e_val  = 1'(ev);
        t.e_id   = 2'(eid);
        t.e_rrdy = 4'(errdy);
        t.e_busy = 1'(ebusy);
        t.e_k    = ek;
        vecs.push_back(t);
    endtask

    task automatic chk(input int idx, input string name, input logic [DW-1:0] got,
                       input logic [DW-1:0] want);
        n_tests++;
        if (got !== want) begin
            n_fail++;
            $display("FAIL vec %0d %s: got %0h want %0h", idx, name, got, want);
        end
    endtask

    initial begin
        logic [DW-1:0] exp_data;
        logic [3:0]    hs;

        // Reset held with all requesters valid, then round-robin over all four.
        v(1, 15, 1, 0, 0, 0, 0, 0);
        v(1, 15, 1, 0, 0, 0, 0, 0);
        v(0, 15, 1, 0, 0, 0, 0, 0);
        for (int r = 0; r < 4; r++)
            for (int b = 0; b < 4; b++) v(0, 15, 1, 1, r, 1 << r, 1, b);
        v(0, 15, 1, 1, 0, 1, 1, 4);
        v(0, 0, 1, 0, 0, 1, 1, 5);
        v(0, 0, 1, 0, 0, 0, 0, 0);

        // Lone requester 1 streams six beats; regranted without a bubble.
        v(1, 0, 1, 0, 0, 0, 0, 0);
        v(0, 2, 1, 0, 0, 0, 0, 0);
        for (int b = 0; b < 6; b++) v(0, 2, 1, 1, 1, 2, 1, b);
        v(0, 0, 1, 0, 1, 2, 1, 6);
        v(0, 0, 1, 0, 1, 0, 0, 0);

        // Backpressure mid-burst on req0; req1 waits for the full burst.
        v(1, 0, 1, 0, 0, 0, 0, 0);
        v(0, 3, 1, 0, 0, 0, 0, 0);
        v(0, 3, 1, 1, 0, 1, 1, 0);
        v(0, 3, 1, 1, 0, 1, 1, 1);
        for (int s = 0; s < 3; s++) v(0, 3, 0, 1, 0, 0, 1, 2);
        v(0, 3, 1, 1, 0, 1, 1, 2);
        v(0, 3, 1, 1, 0, 1, 1, 3);
        v(0, 2, 1, 1, 1, 2, 1, 0);
        v(0, 0, 1, 0, 1, 2, 1, 1);
        v(0, 0, 1, 0, 1, 0, 0, 0);

        // req2 drops after two beats; req3 takes a full burst, then req0.
        v(1, 0, 1, 0, 0, 0, 0, 0);
        v(0, 4, 1, 0, 0, 0, 0, 0);
        v(0, 12, 1, 1, 2, 4, 1, 0);
        v(0, 12, 1, 1, 2, 4, 1, 1);
        v(0, 9, 1, 0, 2, 4, 1, 2);
        for (int b = 0; b < 4; b++) v(0, 9, 1, 1, 3, 8, 1, b);
        v(0, 1, 1, 1, 0, 1, 1, 0);
        v(0, 0, 1, 0, 0, 1, 1, 1);

        // ptr is now 1 so req3 wins; reset after two beats restores ptr=0.
        v(0, 9, 1, 0, 0, 0, 0, 0);
        v(0, 9, 1, 1, 3, 8, 1, 4);
        v(0, 9, 1, 1, 3, 8, 1, 5);
        v(1, 9, 1, 0, 0, 0, 0, 0);
        v(0, 9, 1, 0, 0, 0, 0, 0);
        v(0, 9, 1, 1, 0, 1, 1, 1);
        v(0, 0, 1, 0, 0, 1, 1, 2);
        v(0, 0, 1, 0, 0, 0, 0, 0);

        for (int i = 0; i < 4; i++) k[i] = 0;
        reset    = 1'b1;
        req_val  = '0;
        req_data = '0;
        enq_rdy  = 1'b1;
        @(posedge clk);
        #1;

        for (int n = 0; n < vecs.size(); n++) begin
            reset   = vecs[n].rst;
            req_val = vecs[n].val;
            enq_rdy = vecs[n].rdy;
            if (vecs[n].rst && vecs[n].val == 4'd0)
                for (int i = 0; i < 4; i++) k[i] = 0;
            for (int i = 0; i < 4; i++) req_data[i*DW +: DW] = data_of(i, k[i]);

            @(negedge clk);
            exp_data = vecs[n].e_busy ? data_of(int'(vecs[n].e_id), vecs[n].e_k) : '0;
            chk(n, "enq_val",  DW'(enq_val), DW'(vecs[n].e_val));
            chk(n, "enq_id",   DW'(enq_id),  DW'(vecs[n].e_id));
            chk(n, "req_rdy",  DW'(req_rdy), DW'(vecs[n].e_rrdy));
            chk(n, "busy",     DW'(busy),    DW'(vecs[n].e_busy));
            chk(n, "enq_data", enq_data,     exp_data);
            hs = req_val & req_rdy;

            @(posedge clk);
            for (int i = 0; i < 4; i++) if (hs[i]) k[i]++;
            #1;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
